// File: rtl/alu_seq.sv
// Purpose: WIDTH-bit ALU; logic/add/sub/compare in one cycle, iterative MULU and SRL.
// Latency: 1 cycle for single-cycle ops and SRL by 0; WIDTH+1 for MULU; shamt+1 for SRL.
// Backpressure: start is taken only in IDLE or DONE; start during EXEC is dropped.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       aluop,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] r_hi,
    output logic             V,
    output logic             c3,
    output logic             z
);

    localparam int SW = $clog2(WIDTH);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SLTU = 3'b011;
    localparam logic [2:0] OP_MULU = 3'b100;
    localparam logic [2:0] OP_SRL  = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] lo;
        logic [WIDTH-1:0] hi;
        logic             v;
        logic             c;
    } res_t;

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [SW:0]        cnt_q, cnt_d;
    logic               mul_q, mul_d;
    logic               load;
    res_t               sc_res, res_d;

    logic [WIDTH-1:0]   bin;
    logic [WIDTH:0]     add_full;
    logic               cin_msb;
    logic               ovf;
    logic [SW-1:0]      shamt;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] acc_step;

    // aluop[2] doubles as binvert and carry-in, so SUB and SLT share the adder with ADD
    always_comb begin
        bin      = aluop[2] ? ~b : b;
        add_full = {1'b0, a} + {1'b0, bin} + {{WIDTH{1'b0}}, aluop[2]};
        cin_msb  = add_full[WIDTH-1] ^ a[WIDTH-1] ^ bin[WIDTH-1];
        ovf      = cin_msb ^ add_full[WIDTH];
        shamt    = b[SW-1:0];
        sc_res   = '0;
        case (aluop)
            OP_AND: sc_res.lo = a & b;
            OP_OR:  sc_res.lo = a | b;
            OP_ADD, OP_SUB: begin
                sc_res.lo = add_full[WIDTH-1:0];
                sc_res.v  = ovf;
                sc_res.c  = add_full[WIDTH];
            end
            OP_SLT: begin
                sc_res.lo = {{(WIDTH-1){1'b0}}, add_full[WIDTH-1] ^ ovf};
                sc_res.v  = ovf;
                sc_res.c  = add_full[WIDTH];
            end
            // carry of a + ~b + 1 is exactly "no borrow", i.e. a >= b unsigned
            OP_SLTU: begin
                sc_res.lo = {{(WIDTH-1){1'b0}}, (a < b)};
                sc_res.c  = (a >= b);
            end
            OP_SRL:  sc_res.lo = a;
            default: sc_res = '0;
        endcase
    end

    // Multiplier sits in the low half of acc and is consumed LSB first as the product shifts in
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        acc_step = mul_q ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        cnt_d   = cnt_q;
        mul_d   = mul_q;
        load    = 1'b0;
        res_d   = sc_res;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    mcand_d = a;
                    mul_d   = (aluop == OP_MULU);
                    if (aluop == OP_MULU) begin
                        acc_d   = {{WIDTH{1'b0}}, b};
                        cnt_d   = (SW+1)'(WIDTH);
                        state_d = EXEC;
                    end else if (aluop == OP_SRL && shamt != '0) begin
                        acc_d   = {{WIDTH{1'b0}}, a};
                        cnt_d   = {1'b0, shamt};
                        state_d = EXEC;
                    end else begin
                        load    = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            EXEC: begin
                acc_d = acc_step;
                cnt_d = cnt_q - (SW+1)'(1);
                if (cnt_q == (SW+1)'(1)) begin
                    state_d  = DONE;
                    load     = 1'b1;
                    res_d    = '0;
                    res_d.lo = acc_step[WIDTH-1:0];
                    if (mul_q) begin
                        res_d.hi = acc_step[2*WIDTH-1:WIDTH];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
            mul_q   <= 1'b0;
            r       <= '0;
            r_hi    <= '0;
            V       <= 1'b0;
            c3      <= 1'b0;
            z       <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
            mul_q   <= mul_d;
            if (load) begin
                r    <= res_d.lo;
                r_hi <= res_d.hi;
                V    <= res_d.v;
                c3   <= res_d.c;
                z    <= (res_d.lo == '0);
            end
        end
    end

    assign busy = (state_q == EXEC);
    assign done = (state_q == DONE);

endmodule
